neuron_mac_seq: RTL and testbench

- Sequential dot-product engine directly downstream of the neuron weight ROM.
- Accepts a 144-pixel input vector one pixel per handshake and drives the weight index to the ROM.
- Multiplies each pixel by the four neurons' 35-bit signed weights at that index and accumulates four scores.
- Presents the four scores and the argmax class to the next stage through a valid/ready handshake.

---
 rtl/neuron_mac_seq.sv | 172 +++++++++++++++++
 tb/tb_neuron_mac_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq
//   Sequential dot-product engine sitting directly after the neuron weight ROM.
//   A vector of N_INPUTS unsigned pixels arrives one per handshake. Each pixel
//   is multiplied by the four neurons' signed weights read combinationally from
//   the ROM at w_idx, and the products are accumulated into four signed scores.
//   Once the last pixel is in, one compare cycle registers the argmax class,
//   then the result is presented on a valid/ready handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a new vector (IDLE only)
//   pix_data/valid      pixel stream input
//   pix_ready           engine accepts a pixel this cycle (ACCUM)
//   w_idx               ROM weight index = index of the pixel being accepted
//   w0..w3              signed weights at w_idx for neurons 0..3
//   score0..score3      signed accumulated scores (meaningful when out_valid)
//   class_idx           argmax of the scores, lowest index wins ties
//   out_valid/out_ready result handshake
//   busy                high while accumulating or comparing
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module neuron_mac_seq #(
  parameter int N_INPUTS = 144,
  parameter int PIX_W    = 8,
  parameter int W_W      = 35,
  parameter int ACC_W    = 52
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [PIX_W-1:0]        pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [7:0]              w_idx,
  input  logic signed [W_W-1:0]   w0,
  input  logic signed [W_W-1:0]   w1,
  input  logic signed [W_W-1:0]   w2,
  input  logic signed [W_W-1:0]   w3,
  output logic signed [ACC_W-1:0] score0,
  output logic signed [ACC_W-1:0] score1,
  output logic signed [ACC_W-1:0] score2,
  output logic signed [ACC_W-1:0] score3,
  output logic [1:0]              class_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  // Full-precision product width and the smallest accumulator that cannot
  // overflow over a whole vector.
  localparam int PROD_W  = PIX_W + 1 + W_W;
  localparam int ACC_MIN = PROD_W + $clog2(N_INPUTS);

  localparam logic [7:0] IDX_LAST = 8'(N_INPUTS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  generate
    if (ACC_W < ACC_MIN) begin : g_acc_w_check
      $error("neuron_mac_seq: ACC_W=%0d is below the overflow-free minimum %0d",
             ACC_W, ACC_MIN);
    end
    if (N_INPUTS < 2 || N_INPUTS > 256) begin : g_n_inputs_check
      $error("neuron_mac_seq: N_INPUTS=%0d outside 2..256", N_INPUTS);
    end
  endgenerate

  logic [1:0]              state;
  logic [7:0]              idx;
  logic signed [ACC_W-1:0] acc [4];

  logic signed [PIX_W:0]    pix_s;
  logic signed [W_W-1:0]    w_arr [4];
  logic signed [PROD_W-1:0] prod  [4];
  logic [1:0]               best_idx;
  logic signed [ACC_W-1:0]  best_val;

  // Zero-extend the pixel by one bit so it multiplies as a non-negative
  // signed operand against the signed weights.
  assign pix_s    = signed'({1'b0, pix_data});
  assign w_arr[0] = w0;
  assign w_arr[1] = w1;
  assign w_arr[2] = w2;
  assign w_arr[3] = w3;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      prod[k] = pix_s * w_arr[k];
    end
  end

  // Argmax over the accumulators; only a strictly greater value displaces
  // the current best, so ties resolve to the lowest index.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // up front, otherwise paths that skip the assignment infer a latch.
    best_idx = 2'd0;
    best_val = acc[0];
    for (int k = 1; k < 4; k++) begin
      if (acc[k] > best_val) begin
        best_val = acc[k];
        best_idx = 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulators are reset explicitly (only four registers, not
      // a RAM) so an aborted vector can never leak into the visible scores.
      state     <= S_IDLE;
      idx       <= '0;
      class_idx <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        acc[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            idx   <= '0;
            for (int k = 0; k < 4; k++) begin
              acc[k] <= '0;
            end
          end
        end
        S_ACCUM: begin
          if (pix_valid) begin
            for (int k = 0; k < 4; k++) begin
              acc[k] <= acc[k] + ACC_W'(prod[k]);
            end
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= S_CMP;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        S_CMP: begin
          class_idx <= best_idx;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pix_ready = (state == S_ACCUM);
  assign w_idx     = (state == S_ACCUM) ? idx : 8'd0;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_ACCUM) || (state == S_CMP);

  assign score0 = acc[0];
  assign score1 = acc[1];
  assign score2 = acc[2];
  assign score3 = acc[3];

endmodule

// File: tb/tb_neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_seq
//   Directed bench for neuron_mac_seq. A behavioural weight ROM answers w_idx
//   according to the current pattern mode. Inputs are driven on the falling
//   edge and outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_neuron_mac_seq;

  localparam int N = 144;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [7:0]         pix_data;
  logic               pix_valid;
  logic               pix_ready;
  logic [7:0]         w_idx;
  logic signed [34:0] w0, w1, w2, w3;
  logic signed [51:0] score0, score1, score2, score3;
  logic [1:0]         class_idx;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;

  neuron_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .w_idx     (w_idx),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .score0    (score0),
    .score1    (score1),
    .score2    (score2),
    .score3    (score3),
    .class_idx (class_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pattern modes: 0 unit, 1 extremes, 2 ramp (w = i-k), 3 tie at 500.
  function automatic longint wgt(input int m, input int k, input int i);
    case (m)
      0: begin
        case (k)
          0: return 1;
          1: return 2;
          2: return -1;
          default: return 0;
        endcase
      end
      1: return (k == 0) ? ((64'sd1 <<< 34) - 1) : -(64'sd1 <<< 34);
      2: return longint'(i - k);
      default: return (i < 100) ? 5 : 0;
    endcase
  endfunction

  function automatic int pix(input int m, input int i);
    case (m)
      0: return 1;
      1: return 255;
      2: return (i * 7 + 3) % 256;
      default: return 1;
    endcase
  endfunction

  function automatic longint exp_score(input int m, input int k);
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      s += longint'(pix(m, i)) * wgt(m, k, i);
    end
    return s;
  endfunction

  function automatic int exp_class(input int m);
    int     best   = 0;
    longint best_v = exp_score(m, 0);
    for (int k = 1; k < 4; k++) begin
      if (exp_score(m, k) > best_v) begin
        best_v = exp_score(m, k);
        best   = k;
      end
    end
    return best;
  endfunction

  // Behavioural ROM: combinational from w_idx.
  always_comb begin
    w0 = 35'(wgt(mode, 0, int'(w_idx)));
    w1 = 35'(wgt(mode, 1, int'(w_idx)));
    w2 = 35'(wgt(mode, 2, int'(w_idx)));
    w3 = 35'(wgt(mode, 3, int'(w_idx)));
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input longint e0, input longint e1,
                              input longint e2, input longint e3, input int ec);
    check({tag, "_score0"}, score0, e0);
    check({tag, "_score1"}, score1, e1);
    check({tag, "_score2"}, score2, e2);
    check({tag, "_score3"}, score3, e3);
    check({tag, "_class"},  class_idx, ec);
  endtask

  // Entered and left on a falling edge. pix_valid is held high in IDLE to show
  // it is ignored there.
  task automatic start_vector();
    start     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
  endtask

  // Streams one vector, checking pix_ready and w_idx every cycle, then the
  // single CMP cycle and the rise of out_valid.
  task automatic run_vector(input int m, input bit gaps, input bit poke_start);
    int cnt = 0;
    int cyc = 0;
    while (cnt < N && cyc < 4000) begin
      pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = 8'(pix(m, cnt));
      start     = poke_start && (cyc == 10 || cyc == 77);
      check("accum_pix_ready", pix_ready, 1);
      check("accum_w_idx", w_idx, cnt);
      @(posedge clk);
      if (pix_valid) cnt++;
      cyc++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    check("vector_accepted_count", cnt, N);
    check("cmp_out_valid", out_valid, 0);
    check("cmp_busy", busy, 1);
    check("cmp_pix_ready", pix_ready, 0);
    @(negedge clk);
    check("done_out_valid", out_valid, 1);
    check("done_busy", busy, 0);
    check("done_w_idx", w_idx, 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_out_valid", out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_class", class_idx, 0);
    check("rst_score0", score0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Unit vector
    mode = 0;
    start_vector();
    run_vector(0, 1'b0, 1'b0);
    check_result("unit", 144, 288, -144, 0, 1);
    consume();

    // Reset mid-vector after 70 pixels
    mode = 0;
    start_vector();
    for (int i = 0; i < 70; i++) begin
      pix_valid = 1'b1;
      pix_data  = 8'd1;
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_abort_score0", score0, 70);
    rst_n = 1'b0;
    #1;
    check_result("abort", 0, 0, 0, 0, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pix_ready", pix_ready, 0);
    check("abort_w_idx", w_idx, 0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_vector();
    run_vector(0, 1'b0, 1'b0);
    check_result("post_abort", 144, 288, -144, 0, 1);
    consume();

    // Extremes: 255 * 144 * (2^34-1) and -255 * 144 * 2^34
    mode = 1;
    start_vector();
    run_vector(1, 1'b0, 1'b0);
    check_result("extreme", 64'sd630844796399760, -64'sd630844796436480,
                 -64'sd630844796436480, -64'sd630844796436480, 0);
    consume();

    // Ramp weights, gap-free then throttled
    mode = 2;
    start_vector();
    run_vector(2, 1'b0, 1'b0);
    check_result("ramp", exp_score(2, 0), exp_score(2, 1), exp_score(2, 2),
                 exp_score(2, 3), exp_class(2));
    consume();
    start_vector();
    run_vector(2, 1'b1, 1'b0);
    check_result("ramp_gaps", exp_score(2, 0), exp_score(2, 1), exp_score(2, 2),
                 exp_score(2, 3), exp_class(2));

    // Tie and backpressure
    consume();
    mode = 3;
    start_vector();
    run_vector(3, 1'b0, 1'b0);
    check_result("tie", 500, 500, 500, 500, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
    end
    check("hold_out_valid", out_valid, 1);
    check_result("hold", 500, 500, 500, 500, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_out_valid", out_valid, 1);
    check("done_start_busy", busy, 0);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check("exit_out_valid", out_valid, 0);
    check("exit_busy", busy, 0);
    check("exit_pix_ready", pix_ready, 0);
    @(negedge clk);
    check("idle_hold_busy", busy, 0);
    check_result("idle_keep", 500, 500, 500, 500, 0);

    // Back-to-back with out_ready tied high and start pokes during ACCUM
    out_ready = 1'b1;
    mode = 0;
    start_vector();
    run_vector(0, 1'b0, 1'b0);
    check_result("b2b_a", 144, 288, -144, 0, 1);
    @(negedge clk);
    check("b2b_idle_out_valid", out_valid, 0);
    mode = 2;
    start_vector();
    run_vector(2, 1'b0, 1'b1);
    check_result("b2b_b", exp_score(2, 0), exp_score(2, 1), exp_score(2, 2),
                 exp_score(2, 3), exp_class(2));
    @(negedge clk);
    check("b2b_final_out_valid", out_valid, 0);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
